and_logic_tester: RTL and testbench
===================================

Name: and_logic_tester

Overview:
- Self-checking stimulus/response block: the driving end of the registered two-input AND interface.
- Issues operand pairs on Data1/Data2, samples the DUT's registered Result a fixed number of cycles later, compares it with the expected AND, and reports pass/fail, error count and first failing vector.
- Sits beside the logic-unit DUT on the board or in simulation and is started by a button or testbench pulse.

Parameters:
- VECTORS, 16, number of operand pairs issued per run; legal range 4..255.
- DUT_LAT, 1, DUT clock latency from operand change to Result update; legal range 1..4.
- LFSR_SEED, 8'hA5, nonzero seed loaded into the pattern LFSR at each run start.
- ERR_W, 8, width of the error counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle run request.
- Result  in  1  registered result from the DUT.
- Data1  out  1  operand A to the DUT.
- Data2  out  1  operand B to the DUT.
- Busy  out  1  high while state is RUN or DRAIN.
- Done  out  1  high in DONE.
- Pass  out  1  high in DONE when ErrCount==0.
- ErrCount  out  ERR_W  number of mismatches; saturates.
- FirstErrIdx  out  8  index of the first mismatching vector; 8'hFF if none.

Behaviour:
- Interface decided: one clock CLK; reset RST_N is asynchronous and active-low. All state and outputs are registered on CLK.
- Reset values: Data1=0, Data2=0, Busy=0, Done=0, Pass=0, ErrCount=0, FirstErrIdx=8'hFF, state=IDLE, LFSR=LFSR_SEED, pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: when Start=1, go to RUN and in the same edge:
  - clear ErrCount and set FirstErrIdx=8'hFF;
  - load LFSR=LFSR_SEED;
  - clear the issue and compare counters;
  - drop Done and Pass.
- Start while in RUN or DRAIN is ignored.
- RUN: one vector is issued per clock on Data1/Data2, with issue index i = 0..VECTORS-1.
  - i=0..3 are exhaustive: (D1,D2) = 00, 01, 10, 11.
  - For i>=4: D1=LFSR[0], D2=LFSR[1]; the LFSR advances one step per issued vector i>=4.
  - LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1: shift left, new bit0 = b7^b5^b4^b3.
  - After issuing i=VECTORS-1, go to DRAIN.
  - Outside RUN, Data1=Data2=0.
- Check pipeline: each issued vector pushes (valid=1, expected=D1&D2, index) into a shift pipe DUT_LAT+1 stages deep; non-issue cycles push valid=0.
  - A vector driven at edge t is compared against Result sampled at edge t+DUT_LAT+1.
  - On mismatch, ErrCount increments and saturates at 2^ERR_W-1.
  - On the first mismatch of a run only, FirstErrIdx takes that vector's index.
- DRAIN: lasts until every issued vector has been compared (DUT_LAT+1 cycles), then go to DONE.
- DONE: Done=1 and Pass=(ErrCount==0), both registered. Held until the next Start.
- Busy=1 exactly from the edge entering RUN through the last DRAIN cycle.
  - Total run length is VECTORS+DUT_LAT+1 cycles from Start to Done.
- Reset asserted mid-run aborts immediately to the reset values. No partial result is retained.
- Result is ignored whenever the tail valid bit is 0, including X/garbage from the DUT.

Test Plan:
- Correct DUT (registered AND), DUT_LAT=1, VECTORS=16, Start pulse:
  - Data pairs 00,01,10,11 then LFSR-derived pairs;
  - Done rises 18 cycles after Start with Pass=1, ErrCount=0, FirstErrIdx=8'hFF.
- DUT replaced by registered OR:
  - mismatches at vectors 1 and 2, plus any LFSR vector with D1^D2=1;
  - FirstErrIdx=1, ErrCount equals the reference-model count, Pass=0.
- DUT Result stuck at 1, ERR_W=3, VECTORS=16:
  - ErrCount saturates at 7, FirstErrIdx=0, Pass=0.
- Start pulsed again at cycles 3 and 10 of a run: ignored, and the run completes unchanged.
  - Start in DONE restarts with ErrCount cleared and an identical vector sequence.
- DUT_LAT=3 with a 3-stage delayed AND model:
  - Pass=1, and Done comes 3+16+1=20 cycles after Start;
  - the same model with DUT_LAT=1 gives Pass=0.
- RST_N low mid-RUN at cycle 7:
  - outputs go to reset values asynchronously, before the next CLK edge;
  - after release, a Start gives a full fresh run with Pass=1.

Source files
------------

// File: rtl/and_logic_tester_if.sv
// and_logic_tester_if: operand/result link between the AND tester and the logic-unit DUT.
// Signals:
//   data1  - operand A, driven by the tester
//   data2  - operand B, driven by the tester
//   result - registered AND result returned by the DUT
// Modports: master (tester side), slave (DUT side).
interface and_logic_tester_if;
    logic data1;
    logic data2;
    logic result;
    modport master (output data1, output data2, input result);
    modport slave (input data1, input data2, output result);
endinterface

// File: rtl/and_logic_tester.sv
// and_logic_tester: drives operand pairs into a registered two-input AND DUT,
// checks its delayed result and reports pass/fail, error count and first failing vector.
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   start         - one-cycle run request (honoured in IDLE or DONE only)
//   bus           - master side of the DUT link (data1/data2 out, result in)
//   busy          - high while a run is issuing or draining
//   done          - high once a run has finished, held until the next start
//   pass          - high in DONE when no mismatch was seen
//   err_count     - saturating mismatch count
//   first_err_idx - index of the first mismatching vector, 8'hFF if none
module and_logic_tester #(
    parameter int         VECTORS   = 16,
    parameter int         DUT_LAT   = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         ERR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    and_logic_tester_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [7:0]         first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [7:0]             lfsr;
    logic [7:0]             issue;
    logic                   d1;
    logic                   d2;
    logic [DUT_LAT:0]       pipe_v;
    logic [DUT_LAT:0]       pipe_e;
    logic [DUT_LAT:0][7:0]  pipe_i;
    logic                   launch;
    logic                   issuing;
    logic                   vd1;
    logic                   vd2;
    logic                   mismatch;

    assign launch   = start && (state == IDLE || state == DONE);
    assign issuing  = launch || state == RUN;
    // vector 0 goes out on the launch edge; vectors 1..3 finish the truth table, the rest come from the LFSR
    assign vd1      = launch ? 1'b0 : issue < 8'd4 ? issue[1] : lfsr[0];
    assign vd2      = launch ? 1'b0 : issue < 8'd4 ? issue[0] : lfsr[1];
    // the tail stage lines up with the DUT result for the vector issued DUT_LAT+1 edges earlier
    assign mismatch = pipe_v[DUT_LAT] && (bus.result != pipe_e[DUT_LAT]);
    assign bus.data1 = d1;
    assign bus.data2 = d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= LFSR_SEED;
            issue         <= '0;
            d1            <= 1'b0;
            d2            <= 1'b0;
            pipe_v        <= '0;
            pipe_e        <= '0;
            pipe_i        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 8'hFF;
        end else begin
            pipe_v <= {pipe_v[DUT_LAT-1:0], issuing};
            pipe_e <= {pipe_e[DUT_LAT-1:0], vd1 & vd2};
            pipe_i <= {pipe_i[DUT_LAT-1:0], launch ? 8'd0 : issue};
            d1     <= issuing ? vd1 : 1'b0;
            d2     <= issuing ? vd2 : 1'b0;
            if (launch) begin
                state         <= RUN;
                busy          <= 1'b1;
                done          <= 1'b0;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_idx <= 8'hFF;
                lfsr          <= LFSR_SEED;
                issue         <= 8'd1;
            end else begin
                if (mismatch) begin
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                    if (err_count == '0)
                        first_err_idx <= pipe_i[DUT_LAT];
                end
                case (state)
                    RUN: begin
                        issue <= issue + 8'd1;
                        if (issue >= 8'd4)
                            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        if (issue == 8'(VECTORS - 1))
                            state <= DRAIN;
                    end
                    DRAIN: begin
                        // pipe empty means the last vector was compared on the previous edge
                        if (!(|pipe_v)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_and_logic_tester.sv
// tb_and_logic_tester: directed bench for and_logic_tester against AND, OR, stuck-at-1 and delayed-AND DUT models.
module tb_and_logic_tester;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] st = '0;
    logic [1:0] mode = 2'd0;
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [7:0] err  [3];
    logic [7:0] first [3];
    logic       d1 [3];
    logic       d2 [3];
    logic [2:0] err1;
    logic       and_r;
    logic       or_r;
    logic [2:0] dly0;
    logic [2:0] dly2;
    int         checks = 0;
    int         failures = 0;
    int         lat;
    logic [31:0] seq;

    localparam logic [31:0] SEQ = 32'h1B992F6F;

    always #5 clk = ~clk;

    and_logic_tester_if b0 ();
    and_logic_tester_if b1 ();
    and_logic_tester_if b2 ();

    and_logic_tester #(.VECTORS(16), .DUT_LAT(1), .LFSR_SEED(8'hA5), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bus(b0), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .first_err_idx(first[0]));
    and_logic_tester #(.VECTORS(16), .DUT_LAT(1), .LFSR_SEED(8'hA5), .ERR_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bus(b1), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err1), .first_err_idx(first[1]));
    and_logic_tester #(.VECTORS(16), .DUT_LAT(3), .LFSR_SEED(8'hA5), .ERR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .bus(b2), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err[2]), .first_err_idx(first[2]));

    assign err[1] = {5'd0, err1};
    assign d1[0] = b0.data1;
    assign d2[0] = b0.data2;
    assign d1[1] = b1.data1;
    assign d2[1] = b1.data2;
    assign d1[2] = b2.data1;
    assign d2[2] = b2.data2;

    always_ff @(posedge clk) begin
        and_r <= b0.data1 & b0.data2;
        or_r  <= b0.data1 | b0.data2;
        dly0  <= {dly0[1:0], b0.data1 & b0.data2};
        dly2  <= {dly2[1:0], b2.data1 & b2.data2};
    end

    assign b0.result = mode == 2'd0 ? and_r : mode == 2'd1 ? or_r : dly0[2];
    assign b1.result = 1'b1;
    assign b2.result = dly2[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int u, input bit mid, input string tag);
        lat = 0;
        seq = '0;
        st[u] = 1'b1;
        @(negedge clk);
        st[u] = 1'b0;
        check({tag, "_busy_run"}, 32'(busy[u]), 32'd1);
        while (!done[u] && lat < 100) begin
            if (lat < 16)
                seq = {seq[29:0], d1[u], d2[u]};
            st[u] = mid && (lat == 3 || lat == 10);
            @(negedge clk);
            lat++;
        end
        st[u] = 1'b0;
        check({tag, "_timeout"}, 32'(lat < 100), 32'd1);
        check({tag, "_busy_done"}, 32'(busy[u]), 32'd0);
        check({tag, "_seq"}, seq, SEQ);
    endtask

    task automatic result(input int u, input string tag, input int elat, input bit epass,
                          input int eerr, input int efirst);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_pass"}, 32'(pass[u]), 32'(epass));
        check({tag, "_err"}, 32'(err[u]), 32'(eerr));
        check({tag, "_first"}, 32'(first[u]), 32'(efirst));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_pass", 32'(pass[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_first", 32'(first[0]), 32'hFF);
        check("rst_data", {30'd0, d1[0], d2[0]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 2'd0;
        run(0, 1'b0, "and");
        result(0, "and", 18, 1'b1, 0, 8'hFF);

        mode = 2'd1;
        run(0, 1'b0, "or");
        result(0, "or", 18, 1'b0, 9, 1);

        mode = 2'd0;
        run(0, 1'b1, "restart");
        result(0, "restart", 18, 1'b1, 0, 8'hFF);

        run(1, 1'b0, "stuck");
        result(1, "stuck", 18, 1'b0, 7, 0);

        run(2, 1'b0, "lat3");
        result(2, "lat3", 20, 1'b1, 0, 8'hFF);

        mode = 2'd2;
        run(0, 1'b0, "dly_lat1");
        result(0, "dly_lat1", 18, 1'b0, 8, 3);

        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_err_before", 32'(err[0] != 8'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_err", 32'(err[0]), 32'd0);
        check("arst_first", 32'(first[0]), 32'hFF);
        check("arst_data", {30'd0, d1[0], d2[0]}, 32'd0);
        @(negedge clk);
        mode = 2'd0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(0, 1'b0, "fresh");
        result(0, "fresh", 18, 1'b1, 0, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
